// File: rtl/shift_register_xfer.sv
// ============================================================================
// shift_register_xfer : word <-> serial transfer engine, LANES bits per step.
// Optional macro SHIFT_REGISTER_XFER_ROTATE_EN adds a rotate input port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module shift_register_xfer #(
  parameter int WIDTH = 8,
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             direction,
`ifdef SHIFT_REGISTER_XFER_ROTATE_EN
  input  logic             rotate,
`endif
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic [LANES-1:0] in,
  output logic [LANES-1:0] out,
  output logic [WIDTH-1:0] parallel_out,
  output logic             busy,
  output logic             done
);

  localparam int STEPS = WIDTH / LANES;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  generate
    if (WIDTH < 2 || LANES < 1 || (WIDTH % LANES) != 0) begin : g_bad_param
      $error("shift_register_xfer: WIDTH must be >= 2 and a multiple of LANES");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic [CW-1:0]    r_cnt,   w_cnt_nxt;
  logic             r_dir,   w_dir_nxt;
  logic             r_done,  w_done_nxt;
  logic             r_rot,   w_rot_nxt;
  logic [LANES-1:0] w_exit;
  logic [LANES-1:0] w_enter;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_shr;

  assign w_exit = r_dir ? r_shreg[LANES-1:0] : r_shreg[WIDTH-1 -: LANES];

  // Rotate feeds the exiting group back in, so the word survives the transfer.
`ifdef SHIFT_REGISTER_XFER_ROTATE_EN
  assign w_enter = r_rot ? w_exit : in;
`else
  assign w_enter = in;
`endif

  generate
    if (LANES == WIDTH) begin : g_full_width
      assign w_shl = w_enter;
      assign w_shr = w_enter;
    end else begin : g_partial
      assign w_shl = {r_shreg[WIDTH-LANES-1:0], w_enter};
      assign w_shr = {w_enter, r_shreg[WIDTH-1:LANES]};
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_rot_nxt   = r_rot;
    w_done_nxt  = 1'b0;
    load_ready  = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          w_shreg_nxt = parallel_in;
          w_dir_nxt   = direction;
`ifdef SHIFT_REGISTER_XFER_ROTATE_EN
          w_rot_nxt   = rotate;
`endif
          w_cnt_nxt   = '0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (en) begin
          w_shreg_nxt = r_dir ? w_shr : w_shl;
          if (r_cnt == CW'(STEPS - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_rot   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_rot   <= w_rot_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign out          = w_exit;
  assign parallel_out = r_shreg;
  assign done         = r_done;

endmodule

`default_nettype wire

// File: tb/tb_shift_register_xfer.sv
// Scoreboard bench for shift_register_xfer: LANES=1 and LANES=2 instances.
`default_nettype none

module tb_shift_register_xfer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       direction = 1'b0;
  logic       rotate = 1'b0;

  logic       lv1 = 1'b0, lr1, busy1, done1;
  logic [7:0] pi1 = '0, po1;
  logic [0:0] in1 = '0, out1;

  logic       lv2 = 1'b0, lr2, busy2, done2;
  logic [7:0] pi2 = '0, po2;
  logic [1:0] in2 = '0, out2;

  int vectors = 0;
  int miscompares = 0;
  int run1 = 0, last_run1 = -1;
  int run2 = 0, last_run2 = -1;

  logic [0:0] exp_out1[$];
  logic [7:0] exp_po1[$];
  logic [1:0] exp_out2[$];
  logic [7:0] exp_po2[$];

  always #5 clk = ~clk;

  shift_register_xfer #(.WIDTH(8), .LANES(1)) dut (
    .clk(clk), .rst(rst), .en(en), .direction(direction),
`ifdef SHIFT_REGISTER_XFER_ROTATE_EN
    .rotate(rotate),
`endif
    .load_valid(lv1), .load_ready(lr1), .parallel_in(pi1), .in(in1),
    .out(out1), .parallel_out(po1), .busy(busy1), .done(done1)
  );

  shift_register_xfer #(.WIDTH(8), .LANES(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .direction(direction),
`ifdef SHIFT_REGISTER_XFER_ROTATE_EN
    .rotate(1'b0),
`endif
    .load_valid(lv2), .load_ready(lr2), .parallel_in(pi2), .in(in2),
    .out(out2), .parallel_out(po2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push eight expected serial bits in the order they leave the DUT.
  task automatic push_seq(input logic [7:0] seq);
    for (int i = 7; i >= 0; i--) exp_out1.push_back(seq[i]);
  endtask

  task automatic wait_done(input int sel);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if ((sel == 1) ? done1 : done2) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    #1;
  endtask

  // Monitor for the single-lane instance: a serial group is presented on
  // every enabled busy cycle, the word on every done pulse.
  always @(negedge clk) begin
    if (rst) begin
      run1 = 0;
    end else begin
      if (busy1 && en) begin
        if (exp_out1.size() == 0) chk("out1_unexpected", 32'd1, 32'd0);
        else chk("out1", 32'(out1), 32'(exp_out1.pop_front()));
      end
      if (busy1) run1++;
      if (done1) begin
        last_run1 = run1;
        run1 = 0;
        if (exp_po1.size() == 0) chk("po1_unexpected", 32'd1, 32'd0);
        else chk("parallel_out1", 32'(po1), 32'(exp_po1.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      run2 = 0;
    end else begin
      if (busy2 && en) begin
        if (exp_out2.size() == 0) chk("out2_unexpected", 32'd1, 32'd0);
        else chk("out2", 32'(out2), 32'(exp_out2.pop_front()));
      end
      if (busy2) run2++;
      if (done2) begin
        last_run2 = run2;
        run2 = 0;
        if (exp_po2.size() == 0) chk("po2_unexpected", 32'd1, 32'd0);
        else chk("parallel_out2", 32'(po2), 32'(exp_po2.pop_front()));
      end
    end
  end

  initial begin
    logic done_seen;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_parallel_out", 32'(po1), 32'h00);
    chk("rst_out", 32'(out1), 32'h0);
    chk("rst_busy", 32'(busy1), 32'h0);
    chk("rst_done", 32'(done1), 32'h0);
    chk("rst_load_ready", 32'(lr1), 32'h1);

    // 1: A5 left, in=1
    push_seq(8'b10100101);
    exp_po1.push_back(8'hFF);
    pi1 = 8'hA5; direction = 1'b0; in1 = 1'b1; lv1 = 1'b1;
    tick();
    lv1 = 1'b0;
    wait_done(1);
    chk("t1_busy_cycles", 32'(last_run1), 32'd8);
    tick();
    chk("t1_done_one_cycle", 32'(done1), 32'd0);

    // 2: 3C right, in=0, direction toggled while shifting
    push_seq(8'b00111100);
    exp_po1.push_back(8'h00);
    pi1 = 8'h3C; direction = 1'b1; in1 = 1'b0; lv1 = 1'b1;
    tick();
    lv1 = 1'b0; direction = 1'b0;
    tick();
    direction = 1'b1;
    tick();
    direction = 1'b0;
    wait_done(1);
    chk("t2_busy_cycles", 32'(last_run1), 32'd8);

    // 3: stall 3 cycles after 2nd shift, next word held on load_valid
    push_seq(8'b10100101);
    exp_po1.push_back(8'hFF);
    push_seq(8'b00000000);
    exp_po1.push_back(8'hFF);
    pi1 = 8'hA5; direction = 1'b0; in1 = 1'b1; lv1 = 1'b1;
    tick();
    pi1 = 8'h00;
    tick();
    tick();
    en = 1'b0;
    tick();
    tick();
    tick();
    en = 1'b1;
    wait_done(1);
    chk("t3_busy_cycles", 32'(last_run1), 32'd11);
    chk("t3_ready_in_done", 32'(lr1), 32'd1);
    tick();
    chk("t3_b2b_busy", 32'(busy1), 32'd1);
    chk("t3_b2b_done_drop", 32'(done1), 32'd0);
    lv1 = 1'b0;
    wait_done(1);
    chk("t3_second_busy", 32'(last_run1), 32'd8);

    // 4: reset after three shifts
    exp_out1.push_back(1'b1);
    exp_out1.push_back(1'b0);
    exp_out1.push_back(1'b1);
    pi1 = 8'hA5; in1 = 1'b1; lv1 = 1'b1;
    tick();
    lv1 = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_parallel_out", 32'(po1), 32'h00);
    chk("t4_out", 32'(out1), 32'h0);
    chk("t4_busy", 32'(busy1), 32'h0);
    chk("t4_done", 32'(done1), 32'h0);
    chk("t4_load_ready", 32'(lr1), 32'h1);
    done_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      done_seen = done_seen | done1;
    end
    chk("t4_no_done_pulse", 32'(done_seen), 32'h0);

    // 5: two lanes, B4 left, in=01
    exp_out2.push_back(2'b10);
    exp_out2.push_back(2'b11);
    exp_out2.push_back(2'b01);
    exp_out2.push_back(2'b00);
    exp_po2.push_back(8'h55);
    pi2 = 8'hB4; direction = 1'b0; in2 = 2'b01; lv2 = 1'b1;
    tick();
    lv2 = 1'b0;
    wait_done(2);
    chk("t5_busy_cycles", 32'(last_run2), 32'd4);

`ifdef SHIFT_REGISTER_XFER_ROTATE_EN
    // 6: rotate restores the loaded word
    push_seq(8'b10100101);
    exp_po1.push_back(8'hA5);
    pi1 = 8'hA5; direction = 1'b0; rotate = 1'b1; in1 = 1'b0; lv1 = 1'b1;
    tick();
    lv1 = 1'b0; rotate = 1'b0;
    wait_done(1);
    chk("t6_busy_cycles", 32'(last_run1), 32'd8);
`endif

    tick();
    chk("leftover_out1", 32'(exp_out1.size()), 32'd0);
    chk("leftover_po1", 32'(exp_po1.size()), 32'd0);
    chk("leftover_out2", 32'(exp_out2.size()), 32'd0);
    chk("leftover_po2", 32'(exp_po2.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
